dual_port_dmem: RTL and testbench
=================================

DUAL_PORT_DMEM -- requirements
Module: dual_port_dmem

Interface
REQ-001 Parameter ADDR_W, default 9, SHALL set the word-address width; depth is 2^ADDR_W words.
REQ-002 Parameter DATA_W, default 16, SHALL set the data word width.
REQ-003 Parameter CLR_ON_RST, default 1, SHALL enable (1) or bypass (0) the post-reset memory clear sweep.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-006 p0_DM_maddr  input  ADDR_W  SHALL carry the port-0 word address, sampled every cycle.
REQ-007 p0_DM_wdata  input  DATA_W  SHALL carry the port-0 write data.
REQ-008 p0_DM_write_mem  input  1  SHALL request a port-0 write when high.
REQ-009 p0_DM_rdata  output  DATA_W  SHALL return port-0 read data, registered.
REQ-010 p1_DM_maddr  input  ADDR_W  SHALL carry the port-1 word address, sampled every cycle.
REQ-011 p1_DM_wdata  input  DATA_W  SHALL carry the port-1 write data.
REQ-012 p1_DM_write_mem  input  1  SHALL request a port-1 write when high.
REQ-013 p1_DM_rdata  output  DATA_W  SHALL return port-1 read data, registered.
REQ-014 dm_ready  output  1  SHALL be high only when the block is in RUN.
REQ-015 wr_conflict  output  1  SHALL pulse high for one cycle after both ports write the same address in one cycle.

Function
REQ-016 The controller SHALL have two states: CLEAR and RUN.
REQ-017 In CLEAR, a counter clr_cnt SHALL write 0 to word clr_cnt each cycle, starting at 0 and incrementing by 1.
REQ-018 CLEAR SHALL transition to RUN on the cycle clr_cnt == 2^ADDR_W-1 is written; the sweep SHALL take exactly 2^ADDR_W cycles.
REQ-019 With CLR_ON_RST=0, reset SHALL enter RUN directly and memory contents SHALL be left unchanged.
REQ-020 In CLEAR, port writes SHALL be ignored, both rdata outputs SHALL hold 0, and wr_conflict SHALL hold 0.
REQ-021 In RUN, a port with write_mem high SHALL store its wdata at its maddr at the rising edge.
REQ-022 In RUN, each rdata SHALL present, one cycle after the address is sampled, the contents of that address after that cycle's writes are applied (write-first, covering both ports).
REQ-023 When both ports write the same address in one cycle, p1 data SHALL win, both rdata outputs for that address SHALL return the p1 data, and wr_conflict SHALL be high on the next cycle.
REQ-024 Writes to different addresses in the same cycle SHALL both take effect.
REQ-025 Reads with write_mem low SHALL NOT modify memory; reads have no enable and SHALL occur every RUN cycle.
REQ-026 Address arithmetic SHALL be unsigned ADDR_W bits with no wrap or bounds checking; every address is valid.

Reset
REQ-027 rst high SHALL, at the next edge, force p0_DM_rdata=0, p1_DM_rdata=0, dm_ready=0, wr_conflict=0 and clr_cnt=0.
REQ-028 After that edge, state SHALL be CLEAR when CLR_ON_RST=1, otherwise RUN.
REQ-029 rst asserted mid-sweep or in RUN SHALL restart the sweep from address 0; writes presented during the rst cycle SHALL be dropped.
REQ-030 With CLR_ON_RST=1, dm_ready SHALL first rise exactly 2^ADDR_W cycles after the cycle in which rst is deasserted.

Verification
REQ-031 Release reset with defaults, then count cycles -> dm_ready rises after exactly 512 cycles; reading addresses 0, 255 and 511 afterwards returns 0x0000.
REQ-032 p0 writes 0x0002 to address 3 and p1 writes 0x0004 to address 4 in the same cycle; next cycle p0 reads 4 and p1 reads 3 -> p0_DM_rdata=0x0004 and p1_DM_rdata=0x0002.
REQ-033 p0 writes 0xAAAA and p1 writes 0x5555 to address 10 in the same cycle while both ports address 10 -> both rdata outputs are 0x5555 next cycle, wr_conflict pulses for exactly 1 cycle, and a later read of address 10 returns 0x5555.
REQ-034 p0 writes 0x1234 to address 7 while p1 reads address 7 in the same cycle -> p1_DM_rdata=0x1234 one cycle later (write-first bypass).
REQ-035 Write 0xBEEF to address 20 in RUN, assert rst for 1 cycle, then issue port writes during the sweep -> dm_ready drops at once; after 512 cycles address 20 reads 0x0000 and the sweep-time writes have no effect.

Source files
------------

// File: rtl/dual_port_dmem.sv
// Dual-port data memory with a post-reset clear sweep.
// Two read/write ports share one word array. Reads are registered and
// write-first across both ports; on a same-address double write port 1 wins
// and wr_conflict pulses on the following cycle. After reset the array is
// optionally zeroed one word per cycle before dm_ready is raised.
module dual_port_dmem #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 16,
  parameter int CLR_ON_RST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] p0_DM_maddr,
  input  logic [DATA_W-1:0] p0_DM_wdata,
  input  logic              p0_DM_write_mem,
  output logic [DATA_W-1:0] p0_DM_rdata,
  input  logic [ADDR_W-1:0] p1_DM_maddr,
  input  logic [DATA_W-1:0] p1_DM_wdata,
  input  logic              p1_DM_write_mem,
  output logic [DATA_W-1:0] p1_DM_rdata,
  output logic              dm_ready,
  output logic              wr_conflict
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic              r_dm_ready;
  logic              r_wr_conflict;
  logic [DATA_W-1:0] r_p0_rdata;
  logic [DATA_W-1:0] r_p1_rdata;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_run;
  logic              w_clr_we;
  logic              w_we0;
  logic              w_we1;
  logic              w_same_addr;
  logic              w_sweep_last;
  logic [DATA_W-1:0] w_p0_rd_nxt;
  logic [DATA_W-1:0] w_p1_rd_nxt;

  // Decode write enables, sweep progress, next state and bypassed read data.
  always_comb begin
    w_run        = (r_state == ST_RUN);
    // A reset cycle drops every write, including the sweep's own.
    w_clr_we     = (r_state == ST_CLEAR) && !rst;
    w_we0        = w_run && !rst && p0_DM_write_mem;
    w_we1        = w_run && !rst && p1_DM_write_mem;
    w_same_addr  = (p0_DM_maddr == p1_DM_maddr);
    w_sweep_last = (r_clr_cnt == {ADDR_W{1'b1}});

    w_state_nxt = r_state;
    if (rst) begin
      w_state_nxt = (CLR_ON_RST != 0) ? ST_CLEAR : ST_RUN;
    end else if ((r_state == ST_CLEAR) && w_sweep_last) begin
      w_state_nxt = ST_RUN;
    end

    // Write-first: the freshest data for the addressed word, p1 taking
    // priority over p0, falls back to the stored word.
    if (w_we1 && w_same_addr) begin
      w_p0_rd_nxt = p1_DM_wdata;
    end else if (w_we0) begin
      w_p0_rd_nxt = p0_DM_wdata;
    end else begin
      w_p0_rd_nxt = r_mem[p0_DM_maddr];
    end

    if (w_we1) begin
      w_p1_rd_nxt = p1_DM_wdata;
    end else if (w_we0 && w_same_addr) begin
      w_p1_rd_nxt = p0_DM_wdata;
    end else begin
      w_p1_rd_nxt = r_mem[p1_DM_maddr];
    end
  end

  // Controller: state, sweep counter, ready and conflict flags.
  always_ff @(posedge clk) begin
    r_state <= w_state_nxt;
    if (rst) begin
      r_clr_cnt <= '0;
    end else if (w_clr_we) begin
      r_clr_cnt <= r_clr_cnt + 1'b1;
    end
    // Ready is held low for the reset edge even when the sweep is bypassed.
    r_dm_ready    <= !rst && (w_state_nxt == ST_RUN);
    r_wr_conflict <= w_we0 && w_we1 && w_same_addr;
  end

  // Memory array: sweep clear, or port writes with p1 landing last.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_clr_cnt] <= '0;
    end else begin
      if (w_we0) begin
        r_mem[p0_DM_maddr] <= p0_DM_wdata;
      end
      if (w_we1) begin
        r_mem[p1_DM_maddr] <= p1_DM_wdata;
      end
    end
  end

  // Registered read ports, forced to zero outside RUN.
  always_ff @(posedge clk) begin
    if (rst || !w_run) begin
      r_p0_rdata <= '0;
      r_p1_rdata <= '0;
    end else begin
      r_p0_rdata <= w_p0_rd_nxt;
      r_p1_rdata <= w_p1_rd_nxt;
    end
  end

  assign p0_DM_rdata = r_p0_rdata;
  assign p1_DM_rdata = r_p1_rdata;
  assign dm_ready    = r_dm_ready;
  assign wr_conflict = r_wr_conflict;

endmodule

// File: tb/tb_dual_port_dmem.sv
// Testbench for dual_port_dmem: reset/sweep timing, directed vector table,
// reset-during-run sequence, and randomized traffic against an array model.
module tb_dual_port_dmem;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] a0, a1;
  logic [DATA_W-1:0] d0, d1;
  logic              we0, we1;
  logic [DATA_W-1:0] r0, r1;
  logic              ready, conf;

  dual_port_dmem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLR_ON_RST(1)) dut (
    .clk             (clk),
    .rst             (rst),
    .p0_DM_maddr     (a0),
    .p0_DM_wdata     (d0),
    .p0_DM_write_mem (we0),
    .p0_DM_rdata     (r0),
    .p1_DM_maddr     (a1),
    .p1_DM_wdata     (d1),
    .p1_DM_write_mem (we1),
    .p1_DM_rdata     (r1),
    .dm_ready        (ready),
    .wr_conflict     (conf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: plain array plus run flag and sweep position.
  int unsigned m_mem [DEPTH];
  bit          m_run;
  int          m_cnt;
  int unsigned m_r0, m_r1;
  bit          m_conf, m_ready;

  typedef struct {
    logic              we0;
    logic [ADDR_W-1:0] a0;
    logic [DATA_W-1:0] d0;
    logic              we1;
    logic [ADDR_W-1:0] a1;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] e0;
    logic [DATA_W-1:0] e1;
    logic              econf;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic set_in(input logic w0, input logic [ADDR_W-1:0] x0, input logic [DATA_W-1:0] v0,
                        input logic w1, input logic [ADDR_W-1:0] x1, input logic [DATA_W-1:0] v1);
    we0 = w0; a0 = x0; d0 = v0;
    we1 = w1; a1 = x1; d1 = v1;
  endtask

  // Advance one clock edge and update the model with the inputs held across it.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) begin
      m_run = 0; m_cnt = 0;
      m_r0 = 0; m_r1 = 0; m_conf = 0; m_ready = 0;
    end else if (!m_run) begin
      m_mem[m_cnt] = 0;
      if (m_cnt == DEPTH - 1) m_run = 1;
      m_cnt = m_cnt + 1;
      m_r0 = 0; m_r1 = 0; m_conf = 0; m_ready = m_run;
    end else begin
      if (we0) m_mem[a0] = d0;
      if (we1) m_mem[a1] = d1;
      m_r0 = m_mem[a0];
      m_r1 = m_mem[a1];
      m_conf = we0 && we1 && (a0 == a1);
      m_ready = 1;
    end
  endtask

  // Run a sweep from the current point and return the edges until ready.
  task automatic wait_ready(input string name, input bit random_writes);
    int  cycles;
    bit  nonzero;
    cycles  = 0;
    nonzero = 0;
    while (cycles < 2000) begin
      if (random_writes)
        set_in(1'b1, ADDR_W'($urandom_range(0, DEPTH - 1)), DATA_W'($urandom),
               1'b1, ADDR_W'($urandom_range(0, 31)), DATA_W'($urandom));
      tick();
      cycles++;
      if (ready) break;
      if (r0 !== 0 || r1 !== 0 || conf !== 1'b0) nonzero = 1;
    end
    set_in(1'b0, '0, '0, 1'b0, '0, '0);
    chk({name, "_sweep_cycles"}, cycles, 512);
    chk({name, "_sweep_outputs_zero"}, {31'd0, nonzero}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
    m_run = 0; m_cnt = 0; m_r0 = 0; m_r1 = 0; m_conf = 0; m_ready = 0;

    //               we0  a0     d0        we1  a1     d1        e0        e1        conf
    tbl[0]  = '{1'b1, 9'd3,   16'h0002, 1'b1, 9'd4,   16'h0004, 16'h0002, 16'h0004, 1'b0};
    tbl[1]  = '{1'b0, 9'd4,   16'h0000, 1'b0, 9'd3,   16'h0000, 16'h0004, 16'h0002, 1'b0};
    tbl[2]  = '{1'b1, 9'd10,  16'hAAAA, 1'b1, 9'd10,  16'h5555, 16'h5555, 16'h5555, 1'b1};
    tbl[3]  = '{1'b0, 9'd10,  16'h0000, 1'b0, 9'd10,  16'h0000, 16'h5555, 16'h5555, 1'b0};
    tbl[4]  = '{1'b1, 9'd7,   16'h1234, 1'b0, 9'd7,   16'h0000, 16'h1234, 16'h1234, 1'b0};
    tbl[5]  = '{1'b0, 9'd7,   16'h0000, 1'b0, 9'd20,  16'h0000, 16'h1234, 16'h0000, 1'b0};
    tbl[6]  = '{1'b0, 9'd20,  16'h0000, 1'b1, 9'd20,  16'hBEEF, 16'hBEEF, 16'hBEEF, 1'b0};
    tbl[7]  = '{1'b0, 9'd0,   16'h0000, 1'b0, 9'd255, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    tbl[8]  = '{1'b0, 9'd511, 16'h0000, 1'b0, 9'd20,  16'h0000, 16'h0000, 16'hBEEF, 1'b0};
    tbl[9]  = '{1'b1, 9'd511, 16'h1111, 1'b1, 9'd0,   16'h2222, 16'h1111, 16'h2222, 1'b0};
    tbl[10] = '{1'b0, 9'd0,   16'h0000, 1'b0, 9'd511, 16'h0000, 16'h2222, 16'h1111, 1'b0};

    // Reset state.
    rst = 1'b1;
    set_in(1'b0, '0, '0, 1'b0, '0, '0);
    tick();
    tick();
    chk("rst_p0_rdata", r0, 0);
    chk("rst_p1_rdata", r1, 0);
    chk("rst_dm_ready", ready, 0);
    chk("rst_wr_conflict", conf, 0);

    // Initial sweep, then the cleared corners.
    rst = 1'b0;
    wait_ready("init", 1'b0);

    // Directed vector table.
    for (int i = 0; i < 11; i++) begin
      set_in(tbl[i].we0, tbl[i].a0, tbl[i].d0, tbl[i].we1, tbl[i].a1, tbl[i].d1);
      tick();
      chk($sformatf("vec%0d_p0_rdata", i), r0, tbl[i].e0);
      chk($sformatf("vec%0d_p1_rdata", i), r1, tbl[i].e1);
      chk($sformatf("vec%0d_wr_conflict", i), conf, tbl[i].econf);
      chk($sformatf("vec%0d_dm_ready", i), ready, 1);
    end

    // Reset from RUN with writes presented during the reset cycle.
    rst = 1'b1;
    set_in(1'b1, 9'd5, 16'h7777, 1'b1, 9'd6, 16'h8888);
    tick();
    chk("rerst_dm_ready", ready, 0);
    chk("rerst_p0_rdata", r0, 0);
    chk("rerst_p1_rdata", r1, 0);
    chk("rerst_wr_conflict", conf, 0);
    rst = 1'b0;
    wait_ready("resweep", 1'b1);
    set_in(1'b0, 9'd20, '0, 1'b0, 9'd5, '0);
    tick();
    chk("resweep_addr20", r0, 16'h0000);
    chk("resweep_addr5", r1, 16'h0000);
    set_in(1'b0, 9'd6, '0, 1'b0, 9'd10, '0);
    tick();
    chk("resweep_addr6", r0, 16'h0000);
    chk("resweep_addr10", r1, 16'h0000);

    // Randomized traffic over a small address window to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 15)), DATA_W'($urandom),
             1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 15)), DATA_W'($urandom));
      tick();
      chk("rand_p0_rdata", r0, m_r0);
      chk("rand_p1_rdata", r1, m_r1);
      chk("rand_wr_conflict", conf, m_conf);
      chk("rand_dm_ready", ready, m_ready);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
